// File: rtl/icu_fill_ctl_if.sv
// icu_fill_ctl_if: ICU <-> BIU line-read bus.
// master = fill engine, slave = bus interface unit.
interface icu_fill_ctl_if #(
    parameter int ADDR_W = 32
);
    logic              icu_req;
    logic [ADDR_W-1:0] icu_biu_addr;
    logic [3:0]        icu_type;
    logic [1:0]        icu_size;
    logic [1:0]        biu_icu_ack;
    logic [31:0]       biu_data;

    modport master (
        output icu_req,
        output icu_biu_addr,
        output icu_type,
        output icu_size,
        input  biu_icu_ack,
        input  biu_data
    );

    modport slave (
        input  icu_req,
        input  icu_biu_addr,
        input  icu_type,
        input  icu_size,
        output biu_icu_ack,
        output biu_data
    );
endinterface

// File: rtl/icu_fill_ctl.sv
// icu_fill_ctl: icache miss/fill engine, critical-word-first wrap fill.
// Optional macro ICU_FILL_PERF_EN adds fill_cnt/fill_cyc perf counters.
module icu_fill_ctl #(
    parameter int ADDR_W    = 32,
    parameter int LINE_LOG2 = 2,
    parameter int IDX_W     = 8
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic             iu_psr_ice,
    input  logic             iu_flush_e,
    icu_fill_ctl_if.master   biu,
    output logic             icu_ram_we,
    output logic [IDX_W-1:0] icu_ram_addr,
    output logic [31:0]      icu_din,
    output logic             icu_itag_we,
    output logic             icu_tag_vld,
    output logic             bypass_vld,
    output logic [31:0]      bypass_data,
    output logic             fill_busy,
    output logic             fill_err
`ifdef ICU_FILL_PERF_EN
   ,output logic [15:0]      fill_cnt,
    output logic [15:0]      fill_cyc
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        DRAIN,
        TAGWR
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-3:0]      wa_q, wa_d;
    logic                   ice_q, ice_d;
    logic [LINE_LOG2-1:0]   cnt_q, cnt_d;
    logic                   req_q, req_d;
    logic                   tagok_q, tagok_d;

    logic                   ram_we_q;
    logic [IDX_W-1:0]       ram_addr_q;
    logic [31:0]            din_q;
    logic                   byp_q;
    logic                   err_q;
    logic                   tagwe_q;
    logic                   tagvld_q;

    logic                   ack_dat;
    logic                   ack_err;
    logic                   active;
    logic                   last;
    logic                   take;
    logic [LINE_LOG2-1:0]   off;
    logic                   unused_addr;

    assign unused_addr = ^miss_addr[1:0];

    assign ack_dat = (biu.biu_icu_ack == 2'b01);
    assign ack_err = (biu.biu_icu_ack == 2'b10);
    assign active  = (state_q == REQ) || (state_q == FILL)
                  || (state_q == DRAIN);
    assign last    = !ice_q || (cnt_q == '1);
    assign take    = active && ack_dat;
    assign off     = wa_q[LINE_LOG2-1:0] + cnt_q;

    assign biu.icu_req      = req_q;
    assign biu.icu_biu_addr = req_q ? {wa_q, 2'b00} : '0;
    assign biu.icu_type     = req_q ? {3'b000, ice_q} : 4'b0000;
    assign biu.icu_size     = req_q ? 2'b10 : 2'b00;

    assign icu_ram_we   = ram_we_q;
    assign icu_ram_addr = ram_addr_q;
    assign icu_din      = din_q;
    assign bypass_vld   = byp_q;
    assign bypass_data  = din_q;
    assign icu_itag_we  = tagwe_q;
    assign icu_tag_vld  = tagvld_q;
    assign fill_err     = err_q;
    assign fill_busy    = (state_q != IDLE);

    // Next state: accept a miss, count acks, pick tag/no-tag exit.
    always_comb begin
        state_d = state_q;
        wa_d    = wa_q;
        ice_d   = ice_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        tagok_d = tagok_q;
        if (active && (ack_dat || ack_err)) begin
            req_d = 1'b0;
        end
        if (take) begin
            cnt_d = cnt_q + LINE_LOG2'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (miss_req) begin
                    state_d = REQ;
                    wa_d    = miss_addr[ADDR_W-1:2];
                    ice_d   = iu_psr_ice;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                end
            end
            REQ, FILL, DRAIN: begin
                if (ack_err) begin
                    state_d = ice_q ? TAGWR : IDLE;
                    tagok_d = 1'b0;
                end else if (ack_dat && last) begin
                    if (ice_q && (state_q != DRAIN)) begin
                        state_d = TAGWR;
                        tagok_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (ack_dat || iu_flush_e) begin
                    if (iu_flush_e || (state_q == DRAIN)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            TAGWR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and the registered RAM/bypass/tag strobes.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q    <= IDLE;
            wa_q       <= '0;
            ice_q      <= 1'b0;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            tagok_q    <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            din_q      <= '0;
            byp_q      <= 1'b0;
            err_q      <= 1'b0;
            tagwe_q    <= 1'b0;
            tagvld_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wa_q     <= wa_d;
            ice_q    <= ice_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            tagok_q  <= tagok_d;
            ram_we_q <= take && ice_q;
            if (take) begin
                ram_addr_q <= {wa_q[IDX_W-1:LINE_LOG2], off};
                din_q      <= biu.biu_data;
            end
            byp_q    <= take && (state_q != DRAIN) && !iu_flush_e;
            err_q    <= active && ack_err;
            tagwe_q  <= (state_q == TAGWR);
            tagvld_q <= (state_q == TAGWR) && tagok_q;
        end
    end

`ifdef ICU_FILL_PERF_EN
    logic [15:0] fcnt_q;
    logic [15:0] fcyc_q;

    assign fill_cnt = fcnt_q;
    assign fill_cyc = fcyc_q;

    // Saturating counts of accepted misses and busy cycles.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            fcnt_q <= '0;
            fcyc_q <= '0;
        end else begin
            if ((state_q == IDLE) && miss_req && (fcnt_q != 16'hFFFF)) begin
                fcnt_q <= fcnt_q + 16'd1;
            end
            if (fill_busy && (fcyc_q != 16'hFFFF)) begin
                fcyc_q <= fcyc_q + 16'd1;
            end
        end
    end
`else
    // No performance counters in this configuration.
`endif

`ifndef SYNTHESIS
    ack_idle_a: assert property (
        @(posedge clk) disable iff (!reset_l)
        (state_q == IDLE) |-> !(ack_dat || ack_err)
    );
`endif

endmodule

// File: tb/tb_icu_fill_ctl.sv
// tb_icu_fill_ctl: scoreboard bench for icu_fill_ctl.
// Unit 0 uses 4-word lines, unit 1 uses 16-word lines.
module tb_icu_fill_ctl;

    typedef struct {
        int          u;
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    logic clk;
    logic reset_l;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 0;

    logic        mreq  [2];
    logic [31:0] maddr [2];
    logic        mice  [2];
    logic        flush [2];
    logic [1:0]  ack   [2];
    logic [31:0] bdata [2];

    logic        req      [2];
    logic [31:0] baddr    [2];
    logic [3:0]  btype    [2];
    logic [1:0]  bsize    [2];
    logic        ram_we   [2];
    logic [7:0]  ram_addr [2];
    logic [31:0] din      [2];
    logic        tag_we   [2];
    logic        tag_vld  [2];
    logic        byp_vld  [2];
    logic [31:0] byp_data [2];
    logic        busy     [2];
    logic        ferr     [2];
`ifdef ICU_FILL_PERF_EN
    logic [15:0] fcnt [2];
    logic [15:0] fcyc [2];
`endif

    bit req_p  [2];
    bit busy_p [2];

    ev_t q_rise[$];
    ev_t q_fall[$];
    ev_t q_ram[$];
    ev_t q_byp[$];
    ev_t q_tag[$];
    ev_t q_err[$];
    ev_t q_idle[$];
    ev_t me;

    icu_fill_ctl_if #(.ADDR_W(32)) bus0 ();
    icu_fill_ctl_if #(.ADDR_W(32)) bus1 ();

    assign bus0.biu_icu_ack = ack[0];
    assign bus0.biu_data    = bdata[0];
    assign bus1.biu_icu_ack = ack[1];
    assign bus1.biu_data    = bdata[1];
    assign req[0]   = bus0.icu_req;
    assign baddr[0] = bus0.icu_biu_addr;
    assign btype[0] = bus0.icu_type;
    assign bsize[0] = bus0.icu_size;
    assign req[1]   = bus1.icu_req;
    assign baddr[1] = bus1.icu_biu_addr;
    assign btype[1] = bus1.icu_type;
    assign bsize[1] = bus1.icu_size;

    icu_fill_ctl #(.ADDR_W(32), .LINE_LOG2(2), .IDX_W(8)) dut (
        .clk          (clk),
        .reset_l      (reset_l),
        .miss_req     (mreq[0]),
        .miss_addr    (maddr[0]),
        .iu_psr_ice   (mice[0]),
        .iu_flush_e   (flush[0]),
        .biu          (bus0.master),
        .icu_ram_we   (ram_we[0]),
        .icu_ram_addr (ram_addr[0]),
        .icu_din      (din[0]),
        .icu_itag_we  (tag_we[0]),
        .icu_tag_vld  (tag_vld[0]),
        .bypass_vld   (byp_vld[0]),
        .bypass_data  (byp_data[0]),
        .fill_busy    (busy[0]),
        .fill_err     (ferr[0])
`ifdef ICU_FILL_PERF_EN
       ,.fill_cnt     (fcnt[0]),
        .fill_cyc     (fcyc[0])
`endif
    );

    icu_fill_ctl #(.ADDR_W(32), .LINE_LOG2(4), .IDX_W(8)) dut16 (
        .clk          (clk),
        .reset_l      (reset_l),
        .miss_req     (mreq[1]),
        .miss_addr    (maddr[1]),
        .iu_psr_ice   (mice[1]),
        .iu_flush_e   (flush[1]),
        .biu          (bus1.master),
        .icu_ram_we   (ram_we[1]),
        .icu_ram_addr (ram_addr[1]),
        .icu_din      (din[1]),
        .icu_itag_we  (tag_we[1]),
        .icu_tag_vld  (tag_vld[1]),
        .bypass_vld   (byp_vld[1]),
        .bypass_data  (byp_data[1]),
        .fill_busy    (busy[1]),
        .fill_err     (ferr[1])
`ifdef ICU_FILL_PERF_EN
       ,.fill_cnt     (fcnt[1]),
        .fill_cyc     (fcyc[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int u,
                                logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d: got %0h expected %0h (cycle %0d)",
                     nm, u, act, exp, cyc);
        end
    endfunction

    function automatic void unexp(string nm, int u);
        n_chk++;
        n_fail++;
        $display("FAIL %s u%0d: event at cycle %0d, none expected",
                 nm, u, cyc);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop one expectation per observed output event.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int u = 0; u < 2; u++) begin
                if (req[u] && !req_p[u]) begin
                    if (q_rise.size() == 0) unexp("req_rise", u);
                    else begin
                        me = q_rise.pop_front();
                        chk("req_unit", u, u, me.u);
                        chk("req_rise_cyc", u, cyc, me.cyc);
                        chk("req_addr", u, baddr[u], me.a);
                        chk("req_type", u, 32'(btype[u]), me.b);
                        chk("req_size", u, 32'(bsize[u]), 32'd2);
                    end
                end
                if (!req[u] && req_p[u]) begin
                    if (q_fall.size() == 0) unexp("req_fall", u);
                    else begin
                        me = q_fall.pop_front();
                        chk("req_fall_cyc", u, cyc, me.cyc);
                    end
                end
                if (ram_we[u]) begin
                    if (q_ram.size() == 0) unexp("ram_we", u);
                    else begin
                        me = q_ram.pop_front();
                        chk("ram_unit", u, u, me.u);
                        chk("ram_cyc", u, cyc, me.cyc);
                        chk("ram_addr", u, 32'(ram_addr[u]), me.a);
                        chk("ram_din", u, din[u], me.b);
                    end
                end
                if (byp_vld[u]) begin
                    if (q_byp.size() == 0) unexp("bypass", u);
                    else begin
                        me = q_byp.pop_front();
                        chk("byp_cyc", u, cyc, me.cyc);
                        chk("byp_data", u, byp_data[u], me.a);
                    end
                end
                if (tag_we[u]) begin
                    if (q_tag.size() == 0) unexp("itag_we", u);
                    else begin
                        me = q_tag.pop_front();
                        chk("tag_cyc", u, cyc, me.cyc);
                        chk("tag_vld", u, 32'(tag_vld[u]), me.a);
                    end
                end
                if (ferr[u]) begin
                    if (q_err.size() == 0) unexp("fill_err", u);
                    else begin
                        me = q_err.pop_front();
                        chk("err_cyc", u, cyc, me.cyc);
                    end
                end
                if (!busy[u] && busy_p[u]) begin
                    if (q_idle.size() == 0) unexp("busy_fall", u);
                    else begin
                        me = q_idle.pop_front();
                        chk("idle_cyc", u, cyc, me.cyc);
                    end
                end
                req_p[u]  = req[u];
                busy_p[u] = busy[u];
            end
        end
    end

    // One fill on unit u; expectations are pushed as stimulus is driven.
    task automatic run_fill(input int u, input logic [31:0] addr,
                            input logic ic, input bit issue,
                            input int fw, input int fa, input int ek,
                            input bit hold, input logic [31:0] haddr,
                            input logic hice);
        int          nl;
        int          n;
        logic [7:0]  widx;
        logic [7:0]  msk;
        logic [7:0]  crit;
        logic [7:0]  hi;
        logic [31:0] d;
        bit          drained;
        bit          done;
        nl      = (u == 0) ? 4 : 16;
        n       = ic ? nl : 1;
        widx    = addr[9:2];
        msk     = 8'(nl - 1);
        crit    = widx & msk;
        hi      = widx & ~msk;
        drained = 0;
        done    = 0;
        if (issue) begin
            tick();
            mreq[u]  = 1'b1;
            maddr[u] = addr;
            mice[u]  = ic;
            q_rise.push_back('{u, cyc + 1, {addr[31:2], 2'b00}, 32'(ic)});
        end
        tick();
        mreq[u] = 1'b0;
        for (int k = 0; k < n && !done; k++) begin
            tick();
            if (k == ek) begin
                ack[u]   = 2'b10;
                flush[u] = 1'b0;
                q_err.push_back('{u, cyc + 1, 0, 0});
                if (k == 0) q_fall.push_back('{u, cyc + 1, 0, 0});
                if (ic) begin
                    q_tag.push_back('{u, cyc + 2, 0, 0});
                    q_idle.push_back('{u, cyc + 2, 0, 0});
                end else begin
                    q_idle.push_back('{u, cyc + 1, 0, 0});
                end
                done = 1;
            end else begin
                d        = {8'(u), 8'(k), addr[15:0]};
                ack[u]   = 2'b01;
                bdata[u] = d;
                flush[u] = (k == fw);
                if (k == 0) q_fall.push_back('{u, cyc + 1, 0, 0});
                if (ic) q_ram.push_back('{u, cyc + 1,
                    32'(hi | ((crit + 8'(k)) & msk)), d});
                if (!drained && k != fw)
                    q_byp.push_back('{u, cyc + 1, d, 0});
                if (k == n - 1) begin
                    if (ic && !drained) begin
                        q_tag.push_back('{u, cyc + 2, 1, 0});
                        q_idle.push_back('{u, cyc + 2, 0, 0});
                    end else begin
                        q_idle.push_back('{u, cyc + 1, 0, 0});
                    end
                    if (hold) q_rise.push_back('{u, cyc + 2,
                        {haddr[31:2], 2'b00}, 32'(hice)});
                end else if (k == fw) begin
                    drained = 1;
                end
                if (k == fa) begin
                    tick();
                    ack[u]   = 2'b00;
                    flush[u] = 1'b1;
                    drained  = 1;
                    if (hold) begin
                        mreq[u]  = 1'b1;
                        maddr[u] = haddr;
                        mice[u]  = hice;
                    end
                end
            end
        end
        tick();
        ack[u]   = 2'b00;
        flush[u] = 1'b0;
        if (hold) begin
            tick();
            mreq[u] = 1'b0;
        end else begin
            repeat (4) tick();
        end
    endtask

    initial begin
        reset_l = 1'b0;
        for (int u = 0; u < 2; u++) begin
            mreq[u]   = 1'b0;
            maddr[u]  = '0;
            mice[u]   = 1'b0;
            flush[u]  = 1'b0;
            ack[u]    = 2'b00;
            bdata[u]  = '0;
            req_p[u]  = 0;
            busy_p[u] = 0;
        end
        repeat (3) tick();
        for (int u = 0; u < 2; u++) begin
            chk("rst_req", u, 32'(req[u]), 0);
            chk("rst_addr", u, baddr[u], 0);
            chk("rst_type", u, 32'(btype[u]), 0);
            chk("rst_ram_we", u, 32'(ram_we[u]), 0);
            chk("rst_tag_we", u, 32'(tag_we[u]), 0);
            chk("rst_byp", u, 32'(byp_vld[u]), 0);
            chk("rst_busy", u, 32'(busy[u]), 0);
            chk("rst_err", u, 32'(ferr[u]), 0);
        end
        reset_l = 1'b1;
        mon_en  = 1;
        tick();
        // Wrap fill, critical word at offset 2.
        run_fill(0, 32'h0000_1238, 1'b1, 1, -1, -1, -1, 0, 0, 0);
        // Flush after word 2; next miss held through the drain.
        run_fill(0, 32'h0000_0440, 1'b1, 1, -1, 1, -1,
                 1, 32'h0000_2004, 1'b0);
        // Non-cacheable single read already requested above.
        run_fill(0, 32'h0000_2004, 1'b0, 0, -1, -1, -1, 0, 0, 0);
        // Flush coincident with the last ack.
        run_fill(0, 32'h0000_0A5C, 1'b1, 1, 3, -1, -1, 0, 0, 0);
        // Bus error on the second beat.
        run_fill(0, 32'h0000_0104, 1'b1, 1, -1, -1, 1, 0, 0, 0);
        // 16-word line, critical offset 15.
        run_fill(1, 32'h0000_30FC, 1'b1, 1, -1, -1, -1, 0, 0, 0);
        repeat (4) tick();
`ifdef ICU_FILL_PERF_EN
        chk("fill_cnt", 1, 32'(fcnt[1]), 1);
        chk("fill_cyc", 1, 32'(fcyc[1]), 18);
`endif
        chk("left_rise", 0, q_rise.size(), 0);
        chk("left_fall", 0, q_fall.size(), 0);
        chk("left_ram", 0, q_ram.size(), 0);
        chk("left_byp", 0, q_byp.size(), 0);
        chk("left_tag", 0, q_tag.size(), 0);
        chk("left_err", 0, q_err.size(), 0);
        chk("left_idle", 0, q_idle.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/icu_fill_ctl.md
Name:
icu_fill_ctl

Overview:
Parametrised instruction-cache miss/fill engine for the ICU, the successor to the fixed-line fill logic inside icctl. On a miss it issues one BIU line read and fills the line critical-word-first with wrap-around. It streams each returned word to the ibuffer bypass path, writes the icache RAM, and writes the tag on completion. Fill length, line size and cacheable/non-cacheable mode are generalised, and flush-abort with bus drain is added.

Parameters:
ADDR_W, 32, address width in bits.
LINE_LOG2, 2, log2 of 32-bit words per line; legal range 1..4 (2..16 words).
IDX_W, 8, icache word-index width driven to the RAM.

Ports:
clk  in  1  clock.
reset_l  in  1  synchronous active-low reset.
miss_req  in  1  miss request level, held until fill_busy rises.
miss_addr  in  ADDR_W  byte address of the missed fetch; sampled when a request is accepted.
iu_psr_ice  in  1  icache enable; sampled with miss_req.
iu_flush_e  in  1  abort the current fill.
biu_icu_ack  in  2  2'b01 data word valid, 2'b10 bus error (terminates), others idle.
biu_data  in  32  returned word.
icu_req  out  1  BIU request.
icu_biu_addr  out  ADDR_W  BIU address: word-aligned critical word.
icu_type  out  4  4'b0001 line read (wrapping), 4'b0000 single read.
icu_size  out  2  2'b10 word.
icu_ram_we  out  1  icache RAM word write.
icu_ram_addr  out  IDX_W  RAM word index {line index, wrapped word offset}.
icu_din  out  32  RAM write data.
icu_itag_we  out  1  tag write strobe.
icu_tag_vld  out  1  valid bit written with the tag.
bypass_vld  out  1  bypass word valid.
bypass_data  out  32  bypass word.
fill_busy  out  1  engine not idle.
fill_err  out  1  one-cycle pulse on bus error.

Behaviour:
- Reset (reset_l low at a clk edge): state IDLE; all outputs 0; word counter 0. Reset mid-fill abandons the fill with no tag write. The BIU is reset by the same reset_l.
- States: IDLE, REQ, FILL, DRAIN, TAGWR.
- IDLE: when miss_req=1, capture miss_addr and iu_psr_ice, go to REQ, and set fill_busy=1 from the next cycle.
- REQ: icu_req=1 and icu_biu_addr stay stable until the first ack. If ice=1: icu_type=4'b0001, expected words N=2^LINE_LOG2. If ice=0: icu_type=4'b0000, N=1. icu_req drops in the cycle after the first ack, and the state moves to FILL.
- Word order: offset_k = (crit_offset + k) mod N, with the LINE_LOG2-bit counter wrapping naturally.
- Per ack 2'b01 in REQ or FILL:
  - registered one cycle later, icu_ram_we=1 (ice=1 only), icu_ram_addr=offset_k, icu_din=biu_data;
  - bypass_vld=1 and bypass_data=biu_data in that same cycle;
  - counter increments.
- After the Nth ack:
  - ice=1: go to TAGWR; icu_itag_we=1 and icu_tag_vld=1 for exactly one cycle, then IDLE.
  - ice=0: go straight to IDLE with no tag write.
- Latency: miss_req accepted → icu_req asserted on the next cycle. Last ack → icu_itag_we 2 cycles later.
- Flush (iu_flush_e=1) in REQ or FILL:
  - if icu_req has not yet been acked, icu_req stays asserted, because BIU requests are not cancellable;
  - go to DRAIN.
  - DRAIN continues to count acks and still writes the RAM, since the data is correct. bypass_vld is suppressed.
  - At count N: no tag write (line stays invalid), then IDLE.
- Flush in the same cycle as the Nth ack: tag is written (line complete) and that word's bypass is suppressed.
- Flush in IDLE or TAGWR: no effect on the engine.
- Bus error 2'b10 in any active state:
  - fill_err pulses one cycle;
  - if ice=1, TAGWR writes icu_tag_vld=0;
  - the engine returns to IDLE, and no further acks are expected.
- miss_req while not IDLE is ignored. The requester holds it until IDLE accepts it.
- ack while IDLE is ignored. An implementation assertion flags it in simulation.

Optional Feature:
ICU_FILL_PERF_EN:
- Defined: adds outputs fill_cnt[15:0] and fill_cyc[15:0].
  - fill_cnt increments on every accepted miss.
  - fill_cyc increments every cycle fill_busy=1.
  - Both saturate at 16'hFFFF and are cleared by reset_l.
- Undefined: neither port exists, no counters are built, and behaviour is otherwise identical.

Test Plan:
- LINE_LOG2=2, ice=1, miss_addr=32'h0000_1238: icu_biu_addr=32'h0000_1238, type 4'b0001; RAM offsets written 2,3,0,1; 4 bypass words; one icu_itag_we with vld=1 two cycles after the 4th ack.
- ice=0, miss_addr=32'h0000_2004: type 4'b0000; one ack; bypass_vld once; no icu_ram_we and no icu_itag_we; fill_busy drops.
- Flush after the 2nd ack: bypass stops; RAM writes continue for acks 3-4; no icu_itag_we; IDLE after the 4th ack; a miss_req held during DRAIN is accepted only after IDLE.
- Flush coincident with the 4th ack: icu_itag_we=1 with vld=1; no bypass for word 4.
- Ack 2'b10 after the 1st word: fill_err pulses once; icu_itag_we with icu_tag_vld=0; IDLE.
- LINE_LOG2=4, crit offset 15: offsets 15,0,1..14; 16 writes. Under ICU_FILL_PERF_EN, fill_cnt=1 and fill_cyc equals the number of busy cycles.
